// File: rtl/cpu_arith_pkg.sv
// Shared arithmetic definitions for the CPU datapath: the operand width
// and the state encoding of the bit-serial subtractor.
package cpu_arith_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/serial_subtractor16_if.sv
// Handshake and operand/result bundle between the control unit (master)
// and the bit-serial subtractor (slave).
// SERIAL_SUB_OVF_EN adds the signed-overflow flag to the bundle.
interface serial_subtractor16_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, bout);
  modport slave  (input start, a, b, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor cell: d = a - b - bin, with the outgoing borrow.
// Counterpart of the one-bit cell used by the ripple adder.
module full_subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow-out of a single bit position
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor16.sv
// Bit-serial subtractor: DIFF = A - B, one bit per clock, LSB first.
// Operands are latched on an accepted start; diff/bout update only at the
// end of an operation and hold until the next one completes.
// Optional: define SERIAL_SUB_OVF_EN to add the signed-overflow flag (ovf).
module serial_subtractor16
  import cpu_arith_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_subtractor16_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             d_bit;
  logic             b_next;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
  logic             ovf_r;
`endif

  full_subtractor_1bit u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (b_next)
  );

  // Control FSM plus serial datapath: latch, shift WIDTH bits, publish result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      diff_r <= '0;
      bout_r <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf_r  <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            res_sr <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
`ifdef SERIAL_SUB_OVF_EN
            // Shift registers lose the MSBs, so keep them for the overflow test
            a_msb  <= bus.a[WIDTH-1];
            b_msb  <= bus.b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          res_sr <= {d_bit, res_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          borrow <= b_next;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            busy_r <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          // Result becomes visible only here, never as a partial value
          diff_r <= res_sr;
          bout_r <= borrow;
          done_r <= 1'b1;
          state  <= IDLE;
`ifdef SERIAL_SUB_OVF_EN
          ovf_r  <= (a_msb ^ b_msb) & (a_msb ^ res_sr[WIDTH-1]);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.diff = diff_r;
  assign bus.bout = bout_r;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor16.sv
// Bench for serial_subtractor16: a cycle-level reference model of the
// start/busy/done protocol and A-B arithmetic, compared every cycle, plus
// directed vectors with hand-computed literal results.
module tb_serial_subtractor16;
  import cpu_arith_pkg::*;

  localparam int W = ALU_WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor16_if #(.WIDTH(W)) bus ();

  serial_subtractor16 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted start at edge t0 -> result published at t0+17,
  // busy for edges t0..t0+15, next start accepted from t0+18.
  int         cyc = 0;
  int         m_t0 = 0;
  bit         m_active = 1'b0;
  logic [W-1:0] m_diff = '0;
  logic [W-1:0] p_diff = '0;
  logic       m_bout = 1'b0;
  logic       p_bout = 1'b0;
  logic       m_done = 1'b0;
  logic       m_busy = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
  logic       m_ovf = 1'b0;
  logic       p_ovf = 1'b0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_diff   = '0;
      m_bout   = 1'b0;
      m_done   = 1'b0;
      m_busy   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      m_ovf    = 1'b0;
`endif
    end else begin
      cyc++;
      m_done = 1'b0;
      if (m_active && cyc == m_t0 + 17) begin
        m_diff = p_diff;
        m_bout = p_bout;
        m_done = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
        m_ovf  = p_ovf;
`endif
      end
      if (m_active && cyc >= m_t0 + 18) m_active = 1'b0;
      if (!m_active && bus.start) begin
        m_active = 1'b1;
        m_t0     = cyc;
        p_diff   = bus.a - bus.b;
        p_bout   = (bus.a < bus.b);
`ifdef SERIAL_SUB_OVF_EN
        p_ovf    = (bus.a[W-1] ^ bus.b[W-1]) & (bus.a[W-1] ^ p_diff[W-1]);
`endif
      end
      m_busy = m_active && (cyc < m_t0 + 16);
    end
  end

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    check("busy", {31'b0, bus.busy}, {31'b0, m_busy});
    check("done", {31'b0, bus.done}, {31'b0, m_done});
    check("diff", {16'b0, bus.diff}, {16'b0, m_diff});
    check("bout", {31'b0, bus.bout}, {31'b0, m_bout});
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", {31'b0, bus.ovf}, {31'b0, m_ovf});
`endif
  end

  task automatic do_start(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    bus.a = av;
    bus.b = bv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called at the negedge right after the start edge; lat counts edges from it
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = bus.busy ? 1 : 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = i;
        break;
      end
      if (bus.busy) bcnt++;
    end
    check("done_seen", {31'b0, (lat != 0)}, 32'd1);
  endtask

  task automatic op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                    input logic [W-1:0] ed, input logic eb);
    int lat, bc;
    do_start(av, bv);
    wait_done(lat, bc);
    check({name, "_lat"}, lat, 32'd17);
    check({name, "_diff"}, {16'b0, bus.diff}, {16'b0, ed});
    check({name, "_bout"}, {31'b0, bus.bout}, {31'b0, eb});
  endtask

  initial begin
    int lat, bc, seen;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_diff", {16'b0, bus.diff}, 32'd0);
    check("rst_bout", {31'b0, bus.bout}, 32'd0);
    #2 rst_n = 1'b1;

    // 10 - 9: latency and busy length
    do_start(16'd10, 16'd9);
    wait_done(lat, bc);
    check("t1_lat", lat, 32'd17);
    check("t1_busy_cycles", bc, 32'd16);
    check("t1_diff", {16'b0, bus.diff}, 32'd1);
    check("t1_bout", {31'b0, bus.bout}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("t1_ovf", {31'b0, bus.ovf}, 32'd0);
`endif

    op("t2", 16'd9, 16'd10, 16'hFFFF, 1'b1);
    op("t3", 16'h8000, 16'h0001, 16'h7FFF, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    check("t3_ovf", {31'b0, bus.ovf}, 32'd1);
`endif

    // start re-pulsed while busy is ignored
    do_start(16'd20, 16'd9);
    repeat (3) @(negedge clk);
    bus.a = '0;
    bus.b = '0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, bc);
    check("t4_diff", {16'b0, bus.diff}, 32'd11);
    // start one cycle after done rises is accepted
    bus.a = 16'd15;
    bus.b = 16'd9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, bc);
    check("t4b_lat", lat, 32'd17);
    check("t4b_diff", {16'b0, bus.diff}, 32'd6);

    // start sampled on the edge that raises done is ignored
    do_start(16'd3, 16'd1);
    repeat (16) @(negedge clk);
    bus.a = 16'd7;
    bus.b = 16'd7;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("t5_done", {31'b0, bus.done}, 32'd1);
    check("t5_diff", {16'b0, bus.diff}, 32'd2);
    repeat (3) begin
      @(negedge clk);
      check("t5_idle", {31'b0, bus.busy}, 32'd0);
    end

    // asynchronous reset mid-run
    do_start(16'hFFFF, 16'hFFFF);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", {31'b0, bus.busy}, 32'd0);
    check("t6_done", {31'b0, bus.done}, 32'd0);
    check("t6_diff", {16'b0, bus.diff}, 32'd0);
    check("t6_bout", {31'b0, bus.bout}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check("t6_no_done", seen, 32'd0);
    op("t6b", 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0);

    // operands changing during RUN have no effect
    op("t7pre", 16'd0, 16'd1, 16'hFFFF, 1'b1);
    do_start(16'h1234, 16'h1234);
    repeat (5) @(negedge clk);
    bus.a = 16'h0000;
    bus.b = 16'h0000;
    wait_done(lat, bc);
    check("t7_diff", {16'b0, bus.diff}, 32'd0);
    check("t7_bout", {31'b0, bus.bout}, 32'd0);
    do_start(16'h00F0, 16'h000F);
    repeat (4) @(negedge clk);
    bus.a = 16'hFFFF;
    bus.b = 16'h0000;
    wait_done(lat, bc);
    check("t8_diff", {16'b0, bus.diff}, 32'h00E1);
    check("t8_bout", {31'b0, bus.bout}, 32'd0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
